imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised RV32I/RV64I immediate generator for the pipelined core's decode stage. It accepts a raw 32-bit instruction and decodes the immediate format from the opcode. It sign-extends the assembled immediate (I, S, B, U, J) to XLEN and presents the result through a valid/ready output with a 2-entry skid buffer. It also flags unsupported opcodes and keeps a saturating illegal-opcode counter.

Parameters:
XLEN, 32, output immediate width; legal values are 32 and 64.
CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_instr is valid this cycle
in_ready  output  1  block can accept an instruction this cycle
in_instr  input  32  raw instruction word
out_valid  output  1  out_* fields are valid
out_ready  input  1  downstream accepts the output this cycle
out_imm  output  XLEN  sign-extended immediate
out_fmt  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
out_illegal  output  1  opcode not supported
illegal_cnt  output  CNT_W  count of accepted illegal instructions; saturates

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, illegal_cnt=0. Skid entry is emptied.
- Reset mid-operation: all in-flight data is discarded. No output fires after reset is released until a new instruction is accepted.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Decode on opcode in_instr[6:0]:
  - I (0000011, 0010011, 1100111, 1110011): imm = sext(instr[31:20]).
  - S (0100011): imm = sext({instr[31:25], instr[11:7]}).
  - B (1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}), 13 bits.
  - U (0110111, 0010111): imm = sext({instr[31:12], 12'b0}); for XLEN=64, bit 31 is replicated into bits 63:32.
  - J (1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}), 21 bits.
  - R (0110011): imm=0, fmt=0, illegal=0.
  - Any other opcode: imm=0, fmt=7, illegal=1.
- Sign extension always replicates the top bit of the assembled immediate up to bit XLEN-1.
- Latency: exactly 1 cycle from in_fire to out_valid when the output stage is empty or firing.
- Output stage: a main register plus one skid register.
  - in_ready is registered and equals !skid_full.
  - in_fire with main empty, or with out_fire this cycle: decoded data loads into main.
  - in_fire with main full and no out_fire: decoded data loads into skid; in_ready=0 next cycle.
  - out_fire with skid full: skid moves to main; skid empties; in_ready=1 next cycle.
  - out_fire with skid empty and no in_fire: out_valid=0 next cycle.
- Ordering is strictly FIFO. No instruction is dropped or duplicated.
- out_* fields are held stable while out_valid=1 and out_ready=0.
- illegal_cnt increments by 1 on each in_fire whose opcode decodes as illegal. It holds at 2^CNT_W-1 with no wrap.
- All outputs are driven from registers; there is no combinational path from in_instr to out_*.

Test Plan:
- Reset, then with out_ready=1 send 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- Back-to-back, out_ready=1:
  - 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, out_fmt=2.
  - 0xFE000CE3 (beq, -8) -> out_imm=0xFFFFFFF8, out_fmt=3.
  - 0x0010006F (jal +2048) -> out_imm=0x00000800, out_fmt=5.
  - Each result appears one cycle after acceptance, in order.
- 0x800002B7 (lui x5,0x80000) -> out_imm=0x80000000 at XLEN=32; 0xFFFFFFFF80000000 at XLEN=64; out_fmt=4.
- Backpressure: hold out_ready=0, present 3 valid instructions on consecutive cycles:
  - First two are accepted; in_ready=0 after the second; the third is held.
  - Raise out_ready -> all 3 emerge in order with no loss.
  - out_* stays stable while stalled.
- 0x00000000 and 0x0000007F -> out_fmt=7, out_illegal=1, out_imm=0. illegal_cnt steps 1, then 2.
  - With CNT_W=2, five illegal instructions -> illegal_cnt stays 3.
- Assert rst_n=0 while both main and skid are full -> immediately out_valid=0, in_ready=1, illegal_cnt=0. After release, no stale output ever appears.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator: decodes the immediate format from the opcode and sign-extends
// the immediate to XLEN. Results leave through a valid/ready stage with one skid entry.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpSystem = 7'b1110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [2:0] FmtR   = 3'd0;
    localparam logic [2:0] FmtI   = 3'd1;
    localparam logic [2:0] FmtS   = 3'd2;
    localparam logic [2:0] FmtB   = 3'd3;
    localparam logic [2:0] FmtU   = 3'd4;
    localparam logic [2:0] FmtJ   = 3'd5;
    localparam logic [2:0] FmtIll = 3'd7;

    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_ill;
    logic            w_in_fire;
    logic            w_out_fire;

    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_imm;
    logic [2:0]       r_main_fmt;
    logic             r_main_ill;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic             r_skid_ill;
    logic [CNT_W-1:0] r_cnt;

    // Every immediate is first assembled sign-extended to 32 bits, then widened to XLEN.
    always_comb begin
        w_imm32 = '0;
        w_fmt   = FmtR;
        w_ill   = 1'b0;
        case (in_instr[6:0])
            OpLoad, OpImm, OpJalr, OpSystem: begin
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                w_fmt   = FmtI;
            end
            OpStore: begin
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                w_fmt   = FmtS;
            end
            OpBranch: begin
                w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
                w_fmt   = FmtB;
            end
            OpLui, OpAuipc: begin
                w_imm32 = {in_instr[31:12], 12'b0};
                w_fmt   = FmtU;
            end
            OpJal: begin
                w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
                w_fmt   = FmtJ;
            end
            OpReg: begin
                w_fmt = FmtR;
            end
            default: begin
                w_fmt = FmtIll;
                w_ill = 1'b1;
            end
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));

    assign w_in_fire  = in_valid & ~r_skid_valid;
    assign w_out_fire = r_main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_fmt   <= FmtR;
            r_main_ill   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= FmtR;
            r_skid_ill   <= 1'b0;
        end else begin
            // A full skid blocks input, so in_fire cannot coincide with the skid draining.
            if (w_out_fire && r_skid_valid) begin
                r_main_imm   <= r_skid_imm;
                r_main_fmt   <= r_skid_fmt;
                r_main_ill   <= r_skid_ill;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire && (!r_main_valid || w_out_fire)) begin
                r_main_valid <= 1'b1;
                r_main_imm   <= w_imm;
                r_main_fmt   <= w_fmt;
                r_main_ill   <= w_ill;
            end else if (w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_skid_imm   <= w_imm;
                r_skid_fmt   <= w_fmt;
                r_skid_ill   <= w_ill;
            end else if (w_out_fire) begin
                r_main_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_in_fire && w_ill && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign in_ready    = ~r_skid_valid;
    assign out_valid   = r_main_valid;
    assign out_imm     = r_main_imm;
    assign out_fmt     = r_main_fmt;
    assign out_illegal = r_main_ill;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/CNT_W=8 and a 64-bit/CNT_W=2 instance share one stimulus and
// are checked each cycle against a FIFO-of-two reference model plus directed literal cases.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [7:0]  a_cnt;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [1:0]  b_cnt;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
        .illegal_cnt(a_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
        .illegal_cnt(b_cnt)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   cnt_a = 0;
    int   cnt_b = 0;
    int   n_checks = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: field value as an unsigned number, then two's-complement by subtraction.
    function automatic exp_t ref_dec(input logic [31:0] ins);
        exp_t   e;
        longint v;
        v     = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin
                v = longint'(ins[31:20]);
                if (v >= 2048) v = v - 4096;
                e.fmt = 3'd1;
            end
            7'h23: begin
                v = longint'({ins[31:25], ins[11:7]});
                if (v >= 2048) v = v - 4096;
                e.fmt = 3'd2;
            end
            7'h63: begin
                v = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                if (v >= 4096) v = v - 8192;
                e.fmt = 3'd3;
            end
            7'h37, 7'h17: begin
                v = longint'(ins[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
                e.fmt = 3'd4;
            end
            7'h6F: begin
                v = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
                if (v >= 1048576) v = v - 2097152;
                e.fmt = 3'd5;
            end
            7'h33: e.fmt = 3'd0;
            default: begin
                e.fmt = 3'd7;
                e.ill = 1'b1;
            end
        endcase
        e.imm = 64'(v);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 11))
            0: r[6:0] = 7'h03;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h67;
            3: r[6:0] = 7'h73;
            4: r[6:0] = 7'h23;
            5: r[6:0] = 7'h63;
            6: r[6:0] = 7'h37;
            7: r[6:0] = 7'h17;
            8: r[6:0] = 7'h6F;
            9: r[6:0] = 7'h33;
            10: r[6:0] = 7'h7F;
            default: ;
        endcase
        return r;
    endfunction

    // Per-cycle compare, then advance the model with the handshakes about to happen at posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            cnt_a = 0;
            cnt_b = 0;
            chk("rst a out_valid", 64'(a_out_valid), 64'd0);
            chk("rst b out_valid", 64'(b_out_valid), 64'd0);
            chk("rst a in_ready", 64'(a_in_ready), 64'd1);
            chk("rst b in_ready", 64'(b_in_ready), 64'd1);
            chk("rst a imm", 64'(a_out_imm), 64'd0);
            chk("rst b imm", b_out_imm, 64'd0);
            chk("rst a fmt", 64'(a_out_fmt), 64'd0);
            chk("rst a illegal", 64'(a_out_illegal), 64'd0);
            chk("rst a cnt", 64'(a_cnt), 64'd0);
            chk("rst b cnt", 64'(b_cnt), 64'd0);
        end else begin
            automatic bit can_take = (q.size() < 2);
            chk("a out_valid", 64'(a_out_valid), 64'(q.size() > 0));
            chk("b out_valid", 64'(b_out_valid), 64'(q.size() > 0));
            chk("a in_ready", 64'(a_in_ready), 64'(can_take));
            chk("b in_ready", 64'(b_in_ready), 64'(can_take));
            chk("a illegal_cnt", 64'(a_cnt), 64'(cnt_a));
            chk("b illegal_cnt", 64'(b_cnt), 64'(cnt_b));
            if (q.size() > 0) begin
                chk("a out_imm", 64'(a_out_imm), 64'(q[0].imm[31:0]));
                chk("b out_imm", b_out_imm, q[0].imm);
                chk("a out_fmt", 64'(a_out_fmt), 64'(q[0].fmt));
                chk("b out_fmt", 64'(b_out_fmt), 64'(q[0].fmt));
                chk("a out_illegal", 64'(a_out_illegal), 64'(q[0].ill));
                chk("b out_illegal", 64'(b_out_illegal), 64'(q[0].ill));
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && can_take) begin
                automatic exp_t e = ref_dec(in_instr);
                q.push_back(e);
                if (e.ill) begin
                    if (cnt_a < 255) cnt_a++;
                    if (cnt_b < 3) cnt_b++;
                end
            end
        end
    end

    // Present one instruction with out_ready=1; result must sit in the output stage next cycle.
    task automatic send_chk(input string name, input logic [31:0] ins, input logic [63:0] imm,
                            input logic [2:0] fmt, input logic ill);
        exp_t e;
        e = ref_dec(ins);
        chk({name, " model imm"}, e.imm, imm);
        chk({name, " model fmt"}, 64'(e.fmt), 64'(fmt));
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clk);
        #1;
        chk({name, " out_valid"}, 64'(a_out_valid), 64'd1);
        chk({name, " a imm"}, 64'(a_out_imm), 64'(imm[31:0]));
        chk({name, " b imm"}, b_out_imm, imm);
        chk({name, " fmt"}, 64'(a_out_fmt), 64'(fmt));
        chk({name, " illegal"}, 64'(a_out_illegal), 64'(ill));
    endtask

    task automatic random_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_instr  = rand_instr();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_chk("addi", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        send_chk("sw", 32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
        send_chk("beq", 32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0);
        send_chk("jal", 32'h0010006F, 64'h0000_0000_0000_0800, 3'd5, 1'b0);
        send_chk("lui", 32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
        send_chk("add", 32'h002081B3, 64'h0, 3'd0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Backpressure: two accepted, third held until the stage drains.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        @(posedge clk);
        #1;
        in_instr = 32'hFE112E23;
        @(posedge clk);
        #1;
        chk("bp in_ready after two", 64'(a_in_ready), 64'd0);
        in_instr = 32'h0010006F;
        repeat (3) @(posedge clk);
        #1;
        chk("bp stalled imm", 64'(a_out_imm), 64'hFFFF_FFFF);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp second imm", 64'(a_out_imm), 64'hFFFF_FFFC);
        chk("bp in_ready reopened", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp third imm", 64'(a_out_imm), 64'h0000_0800);
        @(posedge clk);
        #1;
        chk("bp drained", 64'(a_out_valid), 64'd0);

        // Illegal opcodes and counter saturation (b saturates at 3).
        send_chk("ill zero", 32'h0000_0000, 64'h0, 3'd7, 1'b1);
        chk("ill cnt 1", 64'(a_cnt), 64'd1);
        send_chk("ill 7f", 32'h0000_007F, 64'h0, 3'd7, 1'b1);
        chk("ill cnt 2", 64'(a_cnt), 64'd2);
        for (int i = 0; i < 3; i++) send_chk("ill 0b", 32'h1234_560B, 64'h0, 3'd7, 1'b1);
        in_valid = 1'b0;
        chk("ill cnt a 5", 64'(a_cnt), 64'd5);
        chk("ill cnt b sat", 64'(b_cnt), 64'd3);
        @(posedge clk);
        #1;

        random_phase(1500);

        // Fill main and skid, then reset asynchronously between clock edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0000_0000;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-reset skid full", 64'(a_in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 64'(a_out_valid), 64'd0);
        chk("async rst in_ready", 64'(a_in_ready), 64'd1);
        chk("async rst cnt", 64'(a_cnt), 64'd0);
        chk("async rst b out_valid", 64'(b_out_valid), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no stale output", 64'(a_out_valid), 64'd0);

        random_phase(800);
        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
